// File: rtl/ysyx_22040228div_ctrl_pkg.sv
// Opcodes, one-hot state encoding and special-case constants shared
// by the divide controller, its bypass logic and the execute stage.
package ysyx_22040228div_ctrl_pkg;

  localparam logic [7:0] OP_DIV   = 8'h40;
  localparam logic [7:0] OP_DIVU  = 8'h41;
  localparam logic [7:0] OP_REM   = 8'h42;
  localparam logic [7:0] OP_REMU  = 8'h43;
  localparam logic [7:0] OP_DIVW  = 8'h44;
  localparam logic [7:0] OP_DIVUW = 8'h45;
  localparam logic [7:0] OP_REMW  = 8'h46;
  localparam logic [7:0] OP_REMUW = 8'h47;

  localparam logic [63:0] ALL_ONES  = '1;
  localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  localparam int I_IDLE  = 0;
  localparam int I_ISSUE = 1;
  localparam int I_WAIT  = 2;
  localparam int I_DONE  = 3;
  localparam int I_DRAIN = 4;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    ISSUE = 5'b00010,
    WAIT  = 5'b00100,
    DONE  = 5'b01000,
    DRAIN = 5'b10000
  } state_e;

  function automatic logic op_is_w(input logic [7:0] op);
    return op == OP_DIVW || op == OP_REMW;
  endfunction

  function automatic logic op_is_uw(input logic [7:0] op);
    return op == OP_DIVUW || op == OP_REMUW;
  endfunction

  function automatic logic op_is_rem(input logic [7:0] op);
    return op == OP_REM || op == OP_REMU ||
           op == OP_REMW || op == OP_REMUW;
  endfunction

  function automatic logic op_is_signed(input logic [7:0] op);
    return op == OP_DIV || op == OP_REM ||
           op == OP_DIVW || op == OP_REMW;
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22040228div_ctrl_special.sv
// Operand preparation plus divide-by-zero / signed-overflow detection
// and the bypass result that skips the divider.
module ysyx_22040228div_special
  import ysyx_22040228div_ctrl_pkg::*;
(
  input  logic [7:0]  opcode,
  input  logic [63:0] op1,
  input  logic [63:0] op2,
  output logic [63:0] dividend,
  output logic [63:0] diviser,
  output logic [63:0] bypass_result,
  output logic        special
);

  logic        is_w;
  logic        is_uw;
  logic        div_zero;
  logic        ovf;
  logic [63:0] min_val;
  logic [63:0] raw;

  always_comb begin
    is_w     = op_is_w(opcode);
    is_uw    = op_is_uw(opcode);
    dividend = op1;
    diviser  = op2;
    unique case (1'b1)
      is_w: begin
        dividend = sext32(op1[31:0]);
        diviser  = sext32(op2[31:0]);
      end
      is_uw: begin
        dividend = {32'd0, op1[31:0]};
        diviser  = {32'd0, op2[31:0]};
      end
      default: ;
    endcase
    min_val  = is_w ? sext32(INT32_MIN) : INT64_MIN;
    div_zero = diviser == '0;
    ovf      = op_is_signed(opcode) &&
               diviser == ALL_ONES &&
               dividend == min_val;
    special  = div_zero | ovf;
    // overflow quotient is the dividend itself (the most negative value)
    if (div_zero)
      raw = op_is_rem(opcode) ? dividend : ALL_ONES;
    else
      raw = op_is_rem(opcode) ? 64'd0 : dividend;
    bypass_result = (is_w | is_uw) ? sext32(raw[31:0]) : raw;
  end

endmodule

// File: rtl/ysyx_22040228div_ctrl.sv
// Divide controller between execute stage and iterative divider.
// YSYX_22040228_DIV_PERF_EN builds the op / stall perf counters.
module ysyx_22040228div_ctrl
  import ysyx_22040228div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [7:0]  inst_opcode,
  input  logic [63:0] op1,
  input  logic [63:0] op2,
  input  logic        flush,
  output logic        ex_ready,
  output logic [63:0] result,
  output logic        result_valid,
  output logic [63:0] div_dividend,
  output logic [63:0] div_diviser,
  output logic [7:0]  div_opcode,
  output logic        div_ready,
  input  logic [63:0] div_rem_data,
  input  logic        div_finish,
  output logic [63:0] perf_div_ops,
  output logic [63:0] perf_div_stall
);

  state_e      state;
  state_e      state_nxt;
  logic [63:0] dividend;
  logic [63:0] diviser;
  logic [63:0] bypass_result;
  logic        special;
  logic        accept;
  logic        capture;
  logic [63:0] result_q;

  ysyx_22040228div_special u_special (
    .opcode        (inst_opcode),
    .op1           (op1),
    .op2           (op2),
    .dividend      (dividend),
    .diviser       (diviser),
    .bypass_result (bypass_result),
    .special       (special)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      state[I_IDLE]:
        if (ex_valid && !flush)
          state_nxt = special ? DONE : ISSUE;
      state[I_ISSUE]:
        state_nxt = flush ? DRAIN : WAIT;
      state[I_WAIT]:
        // a finish arriving with the flush has nothing left to drain
        if (flush)
          state_nxt = div_finish ? IDLE : DRAIN;
        else if (div_finish)
          state_nxt = DONE;
      state[I_DRAIN]:
        if (div_finish) state_nxt = IDLE;
      state[I_DONE]:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ex_ready     = state[I_IDLE];
    div_ready    = state[I_ISSUE];
    result_valid = state[I_DONE] && !flush;
    result       = result_q;
  end

  assign accept  = state[I_IDLE] && ex_valid && !flush;
  assign capture = state[I_WAIT] && div_finish && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_opcode   <= '0;
      div_dividend <= '0;
      div_diviser  <= '0;
      result_q     <= '0;
    end else if (accept) begin
      div_opcode   <= inst_opcode;
      div_dividend <= dividend;
      div_diviser  <= diviser;
      if (special) result_q <= bypass_result;
    end else if (capture) begin
      result_q <= (op_is_w(div_opcode) || op_is_uw(div_opcode))
                ? sext32(div_rem_data[31:0])
                : div_rem_data;
    end
  end

`ifdef YSYX_22040228_DIV_PERF_EN
  logic [63:0] ops_q;
  logic [63:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      if (result_valid) ops_q   <= ops_q + 64'd1;
      if (!ex_ready)    stall_q <= stall_q + 64'd1;
    end
  end

  assign perf_div_ops   = ops_q;
  assign perf_div_stall = stall_q;
`else
  assign perf_div_ops   = '0;
  assign perf_div_stall = '0;
`endif

endmodule

// File: tb/tb_ysyx_22040228div_ctrl.sv
// Scoreboarded random bench for ysyx_22040228div_ctrl with a stub
// divider and an arithmetic reference model of RV64M divide semantics.
module tb_ysyx_22040228div_ctrl;
  import ysyx_22040228div_ctrl_pkg::*;

  logic        clk = 0;
  logic        rst = 1;
  logic        ex_valid = 0;
  logic [7:0]  inst_opcode = 0;
  logic [63:0] op1 = 0;
  logic [63:0] op2 = 0;
  logic        flush = 0;
  logic        ex_ready;
  logic [63:0] result;
  logic        result_valid;
  logic [63:0] div_dividend;
  logic [63:0] div_diviser;
  logic [7:0]  div_opcode;
  logic        div_ready;
  logic [63:0] div_rem_data = 0;
  logic        div_finish = 0;
  logic [63:0] perf_div_ops;
  logic [63:0] perf_div_stall;

  ysyx_22040228div_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .inst_opcode    (inst_opcode),
    .op1            (op1),
    .op2            (op2),
    .flush          (flush),
    .ex_ready       (ex_ready),
    .result         (result),
    .result_valid   (result_valid),
    .div_dividend   (div_dividend),
    .div_diviser    (div_diviser),
    .div_opcode     (div_opcode),
    .div_ready      (div_ready),
    .div_rem_data   (div_rem_data),
    .div_finish     (div_finish),
    .perf_div_ops   (perf_div_ops),
    .perf_div_stall (perf_div_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] val;
    bit          bypass;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   finish_cyc = 0;
  int   fixed_delay = 0;
  bit   div_abort = 0;
  int   pulses = 0;
  int   exp_pulses = 0;
  int   delivered = 0;
  int   stalls = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check64(input string nm,
                                  input logic [63:0] act,
                                  input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, want);
    end
  endfunction

  // RV64M divide semantics, computed at the ISA level
  function automatic logic [63:0] ref_div(input logic [7:0] op,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
    longint          sa = a;
    longint          sb = b;
    longint unsigned ua = a;
    longint unsigned ub = b;
    int              sa32 = a[31:0];
    int              sb32 = b[31:0];
    int unsigned     ua32 = a[31:0];
    int unsigned     ub32 = b[31:0];
    logic [31:0]     r32;
    bit              ovf64 = (a == 64'h8000_0000_0000_0000) && (sb == -1);
    bit              ovf32 = (a[31:0] == 32'h8000_0000) && (sb32 == -1);
    case (op)
      OP_DIV:  return (b == 0) ? '1 : ovf64 ? a : 64'(sa / sb);
      OP_DIVU: return (b == 0) ? '1 : 64'(ua / ub);
      OP_REM:  return (b == 0) ? a : ovf64 ? 64'd0 : 64'(sa % sb);
      OP_REMU: return (b == 0) ? a : 64'(ua % ub);
      OP_DIVW:
        r32 = (sb32 == 0) ? '1 : ovf32 ? 32'h8000_0000 : 32'(sa32 / sb32);
      OP_DIVUW: r32 = (ub32 == 0) ? '1 : 32'(ua32 / ub32);
      OP_REMW:
        r32 = (sb32 == 0) ? a[31:0] : ovf32 ? 32'd0 : 32'(sa32 % sb32);
      OP_REMUW: r32 = (ub32 == 0) ? a[31:0] : 32'(ua32 % ub32);
      default: r32 = '0;
    endcase
    return {{32{r32[31]}}, r32};
  endfunction

  function automatic bit is_bypass(input logic [7:0] op,
                                   input logic [63:0] a,
                                   input logic [63:0] b);
    case (op)
      OP_DIV, OP_REM:
        return b == 0 || (a == 64'h8000_0000_0000_0000 && b == '1);
      OP_DIVU, OP_REMU: return b == 0;
      OP_DIVW, OP_REMW:
        return b[31:0] == 0 ||
               (a[31:0] == 32'h8000_0000 && b[31:0] == '1);
      default: return b[31:0] == 0;
    endcase
  endfunction

  // stub divider: full-width arithmetic on whatever operands it is given
  function automatic logic [63:0] stub_div(input logic [7:0] op,
                                           input logic [63:0] a,
                                           input logic [63:0] b);
    longint          sa = a;
    longint          sb = b;
    longint unsigned ua = a;
    longint unsigned ub = b;
    bit              rem = (op == OP_REM || op == OP_REMU ||
                            op == OP_REMW || op == OP_REMUW);
    bit              sgn = (op == OP_DIV || op == OP_REM ||
                            op == OP_DIVW || op == OP_REMW);
    if (b == 0) return 64'd0;
    if (sgn && a == 64'h8000_0000_0000_0000 && sb == -1)
      return rem ? 64'd0 : a;
    if (sgn) return rem ? 64'(sa % sb) : 64'(sa / sb);
    return rem ? 64'(ua % ub) : 64'(ua / ub);
  endfunction

  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 9))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return {$urandom, 32'h8000_0000};
      5: return 64'($urandom_range(0, 20));
      6: return {$urandom, 32'd0};
      7: return {$urandom, 32'hFFFF_FFFF};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin : divider
    logic [63:0] d;
    logic [63:0] s;
    logic [7:0]  o;
    int          dly;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (div_ready === 1'b1) begin
        pulses++;
        d = div_dividend;
        s = div_diviser;
        o = div_opcode;
        dly = (fixed_delay != 0) ? fixed_delay : $urandom_range(1, 12);
        aborted = 0;
        for (int i = 0; i < dly; i++) begin
          @(negedge clk);
          if (div_abort) begin
            aborted = 1;
            break;
          end
          check64("stable_dividend", div_dividend, d);
          check64("stable_diviser", div_diviser, s);
          check64("stable_opcode", 64'(div_opcode), 64'(o));
        end
        if (!aborted) begin
          #1;
          div_rem_data = stub_div(o, d, s);
          div_finish = 1;
          finish_cyc = cyc;
          @(negedge clk);
          #1;
          div_finish = 0;
          div_rem_data = {$urandom, $urandom};
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    int   want;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) stalls = 0;
      else if (ex_ready === 1'b0) stalls++;
      if (result_valid === 1'b1) begin
        delivered++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: result_valid=1 result=%h, required no result", result);
        end else begin
          e = exp_q.pop_front();
          check64({e.name, "_result"}, result, e.val);
          want = e.bypass ? e.acc_cyc + 1 : finish_cyc + 1;
          check64({e.name, "_latency"}, 64'(cyc), 64'(want));
        end
      end
    end
  end

  task automatic issue(input logic [7:0] op, input logic [63:0] a,
                       input logic [63:0] b, input bit chk,
                       input string nm);
    int   k;
    exp_t e;
    k = 0;
    @(negedge clk);
    while (!ex_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!ex_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_accept_timeout: ex_ready=%0b required 1", nm, ex_ready);
      return;
    end
    #1;
    inst_opcode = op;
    op1 = a;
    op2 = b;
    ex_valid = 1;
    e.val = ref_div(op, a, b);
    e.bypass = is_bypass(op, a, b);
    e.acc_cyc = cyc;
    e.name = nm;
    if (chk) exp_q.push_back(e);
    if (!e.bypass) exp_pulses++;
    @(negedge clk);
    #1;
    ex_valid = 0;
    op1 = {$urandom, $urandom};
    op2 = {$urandom, $urandom};
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      #2;
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check64({nm, "_ex_ready"}, 64'(ex_ready), 64'd1);
    check64({nm, "_result_valid"}, 64'(result_valid), 64'd0);
    check64({nm, "_div_ready"}, 64'(div_ready), 64'd0);
    check64({nm, "_result"}, result, 64'd0);
    check64({nm, "_div_dividend"}, div_dividend, 64'd0);
    check64({nm, "_div_diviser"}, div_diviser, 64'd0);
    check64({nm, "_div_opcode"}, 64'(div_opcode), 64'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] ops[8];
    int         k;
    bit         hold_ok;
    ops = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU,
            OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};

    #1 rst = 0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    rst = 1;

    issue(OP_DIVU, 64'd100, 64'd7, 1, "divu_100_7");
    drain();
    check64("divu_one_pulse", 64'(pulses), 64'd1);
    issue(OP_REMW, 64'h0000_0000_FFFF_FFF9, 64'd2, 1, "remw_m7_2");
    drain();
    issue(OP_DIV, 64'd1234, 64'd0, 1, "div_by_zero");
    drain();
    check64("div_zero_no_pulse", 64'(pulses), 64'd2);
    issue(OP_REM, 64'h8000_0000_0000_0000, '1, 1, "rem_ovf");
    drain();
    issue(OP_DIVW, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF,
          1, "divw_ovf");
    drain();
    issue(OP_REMUW, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000,
          1, "remuw_zero");
    drain();
    issue(OP_DIVUW, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 1, "divuw_big");
    drain();

    for (int i = 0; i < 200; i++) begin
      issue(ops[$urandom_range(0, 7)], pick64(),
            ($urandom_range(0, 5) == 0) ? 64'd0 : pick64(), 1, "rand");
      drain();
    end

    // flush in WAIT: hold until the divider finishes, then drop it
    fixed_delay = 25;
    issue(OP_DIVU, 64'd1000, 64'd3, 0, "flushed");
    repeat (11) @(negedge clk);
    #1 flush = 1;
    @(negedge clk);
    #1 flush = 0;
    hold_ok = 1;
    k = 0;
    @(negedge clk);
    #2;
    while (!div_finish && k < 100) begin
      if (ex_ready) hold_ok = 0;
      @(negedge clk);
      #2;
      k++;
    end
    if (ex_ready || !div_finish) hold_ok = 0;
    check64("flush_hold", 64'(hold_ok), 64'd1);
    @(negedge clk);
    #2 check64("flush_release", 64'(ex_ready), 64'd1);
    fixed_delay = 0;
    issue(OP_DIVU, 64'd9, 64'd3, 1, "divu_9_3_after_flush");
    drain();

    // asynchronous reset in WAIT abandons the op
    fixed_delay = 30;
    issue(OP_DIVU, 64'd77, 64'd5, 0, "reset_victim");
    repeat (5) @(negedge clk);
    #1;
    div_abort = 1;
    rst = 0;
    #1 check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    #1 rst = 1;
    delivered = 0;
    repeat (3) @(negedge clk);
    #1 check64("post_reset_idle", 64'(ex_ready), 64'd1);
    div_abort = 0;
    fixed_delay = 0;
    repeat (20) @(negedge clk);

    issue(OP_REMU, 64'd100, 64'd7, 1, "remu_after_reset");
    drain();
    issue(OP_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1, "div_neg");
    drain();
    repeat (2) @(negedge clk);
    #1;
    check64("div_ready_pulses", 64'(pulses), 64'(exp_pulses));
`ifdef YSYX_22040228_DIV_PERF_EN
    check64("perf_ops", perf_div_ops, 64'(delivered));
    check64("perf_stall", perf_div_stall, 64'(stalls));
`else
    check64("perf_ops_tied", perf_div_ops, 64'd0);
    check64("perf_stall_tied", perf_div_stall, 64'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
